alarm_ring_ctrl: RTL

Alarm ringing and snooze controller sitting directly downstream of the alarm clock's time-match logic. It consumes the clock's level `Alarm` output, drives the buzzer with an optional beep pattern, and handles snooze re-arming, the snooze limit and the ring timeout. It returns a one-cycle `alarm_clear` pulse that is wired to the clock's `STOP_al` input. Everything runs on the 1 Hz tick, so all counts are in seconds.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_ring_ctrl_if.sv | 26 ++
 rtl/alarm_sec_timer.sv | 39 +++
 rtl/alarm_ring_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm ringing/snooze controller.
// Width helpers keep the snooze counter and snooze timer sized from their limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_t;

    localparam int RING_TIMEOUT_DEF = 60;
    localparam int SNOOZE_SECS_DEF  = 300;
    localparam int MAX_SNOOZE_DEF   = 3;

    // Never return a zero width, even for degenerate limits of 1.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int max_snooze);
        return width_of(max_snooze + 1);
    endfunction

    function automatic int left_w(input int snooze_secs);
        return width_of(snooze_secs);
    endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Button/alarm inputs and buzzer/status outputs of the alarm ringing controller.
// master drives the buttons and alarm level; slave is the controller.
interface alarm_ring_ctrl_if #(
    parameter int CNT_W  = alarm_pkg::cnt_w(alarm_pkg::MAX_SNOOZE_DEF),
    parameter int LEFT_W = alarm_pkg::left_w(alarm_pkg::SNOOZE_SECS_DEF)
);
    logic              alarm_in;
    logic              snooze;
    logic              stop;
    logic              buzzer;
    logic              alarm_clear;
    logic              snoozing;
    logic [CNT_W-1:0]  snooze_cnt;
    logic [LEFT_W-1:0] snooze_left;
    logic              missed;

    modport master (
        output alarm_in, snooze, stop,
        input  buzzer, alarm_clear, snoozing, snooze_cnt, snooze_left, missed
    );

    modport slave (
        input  alarm_in, snooze, stop,
        output buzzer, alarm_clear, snoozing, snooze_cnt, snooze_left, missed
    );
endinterface

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter with clear, enable and zero flag; one tick per clk_1s edge.
// Load beats enable; clear beats both; holds at zero rather than wrapping.
module alarm_sec_timer #(
    parameter int W = 9
) (
    input  logic         clk_1s,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze FSM: reacts one clk_1s edge after an alarm_in rise; all outputs registered.
// Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off buzzer in RING instead of a steady tone.
module alarm_ring_ctrl #(
    parameter int RING_TIMEOUT = alarm_pkg::RING_TIMEOUT_DEF,
    parameter int SNOOZE_SECS  = alarm_pkg::SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE   = alarm_pkg::MAX_SNOOZE_DEF
) (
    input  logic             clk_1s,
    input  logic             reset,
    alarm_ring_ctrl_if.slave bus
);
    import alarm_pkg::*;

    localparam int CNT_W  = cnt_w(MAX_SNOOZE);
    localparam int LEFT_W = left_w(SNOOZE_SECS);
    localparam int RC_W   = width_of(RING_TIMEOUT);

    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_SNOOZE);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RING_TIMEOUT - 1);
    localparam logic [LEFT_W-1:0] SNZ_LOAD = LEFT_W'(SNOOZE_SECS - 1);

`ifdef ALARM_BEEP_PATTERN_EN
    localparam logic BEEP_EN = 1'b1;
`else
    localparam logic BEEP_EN = 1'b0;
`endif

    ring_state_t       state_q;
    logic              alarm_dly_q;
    logic [RC_W-1:0]   ring_cnt_q;
    logic [CNT_W-1:0]  snooze_cnt_q;
    logic              buzzer_q;
    logic              clear_q;
    logic              snoozing_q;
    logic              missed_q;

    logic              rise;
    logic              snz_take;
    logic [RC_W-1:0]   ring_inc;
    logic              tmr_clr;
    logic              tmr_load;
    logic              tmr_en;
    logic [LEFT_W-1:0] snooze_left;
    logic              snooze_zero;

    assign rise     = bus.alarm_in & ~alarm_dly_q;
    assign snz_take = bus.snooze && (snooze_cnt_q < MAX_CNT);
    assign ring_inc = ring_cnt_q + RC_W'(1);

    // Snooze timer moves in lockstep with the FSM's SNOOZE entry and exit decisions.
    assign tmr_load = (state_q == RING)   && !bus.stop && snz_take;
    assign tmr_en   = (state_q == SNOOZE) && !bus.stop;
    assign tmr_clr  = (state_q == SNOOZE) &&  bus.stop;

    alarm_sec_timer #(.W(LEFT_W)) u_snooze_timer (
        .clk_1s     (clk_1s),
        .reset      (reset),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (SNZ_LOAD),
        .en_i       (tmr_en),
        .cnt_o      (snooze_left),
        .zero_o     (snooze_zero)
    );

    // alarm_dly_q resets high so an alarm already asserted at reset release is not a rise.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            alarm_dly_q  <= 1'b1;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            buzzer_q     <= 1'b0;
            clear_q      <= 1'b0;
            snoozing_q   <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            alarm_dly_q <= bus.alarm_in;
            clear_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q      <= RING;
                        ring_cnt_q   <= '0;
                        snooze_cnt_q <= '0;
                        missed_q     <= 1'b0;
                        buzzer_q     <= 1'b1;
                        snoozing_q   <= 1'b0;
                    end else if (bus.stop) begin
                        missed_q <= 1'b0;
                    end
                end
                RING: begin
                    if (bus.stop) begin
                        state_q      <= IDLE;
                        clear_q      <= 1'b1;
                        snooze_cnt_q <= '0;
                        buzzer_q     <= 1'b0;
                    end else if (snz_take) begin
                        state_q      <= SNOOZE;
                        snooze_cnt_q <= snooze_cnt_q + CNT_W'(1);
                        clear_q      <= 1'b1;
                        buzzer_q     <= 1'b0;
                        snoozing_q   <= 1'b1;
                    end else if (ring_cnt_q == RC_LAST) begin
                        state_q  <= IDLE;
                        clear_q  <= 1'b1;
                        missed_q <= 1'b1;
                        buzzer_q <= 1'b0;
                    end else begin
                        ring_cnt_q <= ring_inc;
                        buzzer_q   <= ~ring_inc[0] | ~BEEP_EN;
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        state_q      <= IDLE;
                        snooze_cnt_q <= '0;
                        snoozing_q   <= 1'b0;
                    end else if (snooze_zero) begin
                        state_q    <= RING;
                        ring_cnt_q <= '0;
                        buzzer_q   <= 1'b1;
                        snoozing_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    buzzer_q   <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.alarm_clear = clear_q;
    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_cnt  = snooze_cnt_q;
    assign bus.snooze_left = snooze_left;
    assign bus.missed      = missed_q;
endmodule
